// File: rtl/ttc_lock_ctrl.sv
// ttc_lock_ctrl: picks a word-alignment channel from the 16 SR16 valid flags,
// confirms it with LOCK_COUNT periodic hits, then forwards that channel's words.
// Lock is dropped after UNLOCK_COUNT consecutive on-phase misses or force_realign,
// followed by a HOLDOFF_CYCLES quiet period before searching again.
// Strobe semantics: valid_o is a one-cycle qualifier for dataout with no ready/
// backpressure; the consumer must take the word on the cycle valid_o is high.
module ttc_lock_ctrl #(
    parameter int FRAME_LEN      = 16,
    parameter int LOCK_COUNT     = 8,
    parameter int UNLOCK_COUNT   = 4,
    parameter int HOLDOFF_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  valid_in,
    input  logic [255:0] data_in,
    input  logic         force_realign,
    output logic         valid_o,
    output logic [15:0]  dataout,
    output logic         locked,
    output logic [3:0]   sel_channel,
    output logic         lock_lost,
    output logic [7:0]   relock_count,
    output logic [1:0]   state_dbg
);

    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0]    HIT_LAST   = 8'(LOCK_COUNT - 1);
    localparam logic [7:0]    MISS_LAST  = 8'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase_cnt, phase_nx;
    logic [7:0]    hit_cnt, hit_nx;
    logic [7:0]    miss_cnt, miss_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [3:0]    sel_nx;
    logic          valid_nx;
    logic [15:0]   data_nx;
    logic          lost_nx;
    logic [7:0]    relock_nx;

    logic [3:0]    low_idx;
    logic          on_phase;
    logic          sel_valid;
    logic [15:0]   sel_word;
    logic [7:0]    relock_inc;

    assign on_phase   = (phase_cnt == PHASE_LAST);
    assign sel_valid  = valid_in[sel_channel];
    assign sel_word   = data_in[{sel_channel, 4'b0000} +: 16];
    assign relock_inc = (relock_count == 8'hFF) ? 8'hFF : relock_count + 8'd1;
    assign locked     = (state == ST_LOCKED);
    assign state_dbg  = state;

    // Priority encoder: lowest-numbered channel with a valid flag wins.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (valid_in[i]) low_idx = 4'(i);
        end
    end

    // Next-state and next-output logic for the search/confirm/lock/holdoff FSM.
    always_comb begin
        state_nx  = state;
        phase_nx  = on_phase ? '0 : phase_cnt + 1'b1;
        hit_nx    = hit_cnt;
        miss_nx   = miss_cnt;
        hold_nx   = hold_cnt;
        sel_nx    = sel_channel;
        valid_nx  = 1'b0;
        data_nx   = dataout;
        lost_nx   = 1'b0;
        relock_nx = relock_count;
        case (state)
            ST_SEARCH: begin
                if (|valid_in) begin
                    sel_nx   = low_idx;
                    phase_nx = '0;
                    hit_nx   = 8'd0;
                    state_nx = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (force_realign) begin
                    state_nx  = ST_HOLDOFF;
                    hold_nx   = '0;
                    relock_nx = relock_inc;
                end else if (on_phase && sel_valid) begin
                    hit_nx = hit_cnt + 8'd1;
                    if (hit_cnt == HIT_LAST) begin
                        state_nx = ST_LOCKED;
                        miss_nx  = 8'd0;
                        valid_nx = 1'b1;
                        data_nx  = sel_word;
                    end
                end else if (on_phase || sel_valid) begin
                    state_nx = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (force_realign) begin
                    state_nx  = ST_HOLDOFF;
                    hold_nx   = '0;
                    lost_nx   = 1'b1;
                    relock_nx = relock_inc;
                end else if (on_phase) begin
                    if (sel_valid) begin
                        miss_nx  = 8'd0;
                        valid_nx = 1'b1;
                        data_nx  = sel_word;
                    end else begin
                        miss_nx = miss_cnt + 8'd1;
                        if (miss_cnt == MISS_LAST) begin
                            state_nx  = ST_HOLDOFF;
                            hold_nx   = '0;
                            lost_nx   = 1'b1;
                            relock_nx = relock_inc;
                        end
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = ST_SEARCH;
                    hold_nx  = '0;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: state_nx = ST_SEARCH;
        endcase
    end

    // State, counter and registered-output updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_SEARCH;
            phase_cnt    <= '0;
            hit_cnt      <= 8'd0;
            miss_cnt     <= 8'd0;
            hold_cnt     <= '0;
            sel_channel  <= 4'd0;
            valid_o      <= 1'b0;
            dataout      <= 16'd0;
            lock_lost    <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            state        <= state_nx;
            phase_cnt    <= phase_nx;
            hit_cnt      <= hit_nx;
            miss_cnt     <= miss_nx;
            hold_cnt     <= hold_nx;
            sel_channel  <= sel_nx;
            valid_o      <= valid_nx;
            dataout      <= data_nx;
            lock_lost    <= lost_nx;
            relock_count <= relock_nx;
        end
    end

endmodule

// File: tb/tb_ttc_lock_ctrl.sv
// Bench for ttc_lock_ctrl: directed stimulus, a cycle-count based reference
// model, a per-cycle compare process and an expected-word queue.
module tb_ttc_lock_ctrl;

    localparam int FRAME_LEN      = 16;
    localparam int LOCK_COUNT     = 8;
    localparam int UNLOCK_COUNT   = 4;
    localparam int HOLDOFF_CYCLES = 32;

    localparam int M_SEARCH  = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_LOCKED  = 2;
    localparam int M_HOLDOFF = 3;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         reset;
    logic [15:0]  valid_in;
    logic [255:0] data_in;
    logic         force_realign;
    logic         valid_o;
    logic [15:0]  dataout;
    logic         locked;
    logic [3:0]   sel_channel;
    logic         lock_lost;
    logic [7:0]   relock_count;
    logic [1:0]   state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ttc_lock_ctrl #(
        .FRAME_LEN(FRAME_LEN), .LOCK_COUNT(LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT), .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .force_realign(force_realign), .valid_o(valid_o), .dataout(dataout),
        .locked(locked), .sel_channel(sel_channel), .lock_lost(lock_lost),
        .relock_count(relock_count), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase is derived from the cycle distance to the capture; hit count and
    // miss count are derived from elapsed frames rather than kept as counters.
    int          cyc, t_cap, last_hit, hold_end, m_state;
    logic [3:0]  m_sel;
    logic        m_valid, m_lost;
    logic [15:0] m_data;
    logic [7:0]  m_relock;

    task automatic model_reset();
        m_state  = M_SEARCH;
        m_sel    = 4'd0;
        m_valid  = 1'b0;
        m_lost   = 1'b0;
        m_data   = 16'd0;
        m_relock = 8'd0;
        t_cap    = 0;
        last_hit = 0;
        hold_end = 0;
        exp_q.delete();
    endtask

    task automatic enter_holdoff(input logic lost);
        m_state  = M_HOLDOFF;
        hold_end = cyc + HOLDOFF_CYCLES;
        m_lost   = lost;
        if (m_relock != 8'hFF) m_relock = m_relock + 8'd1;
    endtask

    task automatic model_step();
        logic        sv;
        logic [15:0] word;
        logic        onp;
        int          rel;
        bit          found;
        cyc++;
        m_valid = 1'b0;
        m_lost  = 1'b0;
        sv   = valid_in[m_sel];
        word = data_in[16*m_sel +: 16];
        rel  = cyc - t_cap;
        onp  = (rel > 0) && (rel % FRAME_LEN == 0);
        case (m_state)
            M_SEARCH: begin
                found = 0;
                for (int i = 0; i < 16; i++) begin
                    if (!found && valid_in[i]) begin
                        found = 1;
                        m_sel = 4'(i);
                    end
                end
                if (found) begin
                    t_cap   = cyc;
                    m_state = M_CONFIRM;
                end
            end
            M_CONFIRM: begin
                if (force_realign) enter_holdoff(1'b0);
                else if (onp && sv) begin
                    if (rel / FRAME_LEN == LOCK_COUNT) begin
                        m_state  = M_LOCKED;
                        last_hit = cyc;
                        m_valid  = 1'b1;
                        m_data   = word;
                        exp_q.push_back(word);
                    end
                end else if (onp || sv) m_state = M_SEARCH;
            end
            M_LOCKED: begin
                if (force_realign) enter_holdoff(1'b1);
                else if (onp) begin
                    if (sv) begin
                        last_hit = cyc;
                        m_valid  = 1'b1;
                        m_data   = word;
                        exp_q.push_back(word);
                    end else if ((cyc - last_hit) / FRAME_LEN >= UNLOCK_COUNT) begin
                        enter_holdoff(1'b1);
                    end
                end
            end
            default: begin
                if (cyc == hold_end) m_state = M_SEARCH;
            end
        endcase
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("valid_o", 32'(valid_o), 32'(m_valid));
            check("dataout", 32'(dataout), 32'(m_data));
            check("locked", 32'(locked), 32'(m_state == M_LOCKED));
            check("sel_channel", 32'(sel_channel), 32'(m_sel));
            check("lock_lost", 32'(lock_lost), 32'(m_lost));
            check("relock_count", 32'(relock_count), 32'(m_relock));
            check("state_dbg", 32'(state_dbg), 32'(m_state));
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) check("word_queue_empty", 32'(dataout), 32'hFFFF_FFFF);
                else check("word_queue", 32'(dataout), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int ch);
        valid_in = 16'd1 << ch;
        @(negedge clk);
        valid_in = 16'd0;
    endtask

    task automatic set_word(input int ch, input logic [15:0] w);
        data_in[16*ch +: 16] = w;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_o"}, 32'(valid_o), 32'd0);
        check({tag, "_dataout"}, 32'(dataout), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_sel"}, 32'(sel_channel), 32'd0);
        check({tag, "_lost"}, 32'(lock_lost), 32'd0);
        check({tag, "_relock"}, 32'(relock_count), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset         = 1'b0;
        valid_in      = 16'd0;
        force_realign = 1'b0;
        for (int i = 0; i < 16; i++) data_in[16*i +: 16] = 16'h1100 * 16'(i) + 16'h0011;
        set_word(5, 16'hA5C3);
        set_word(7, 16'h7E57);

        // Reset state
        tick(3);
        check_all_zero("reset");
        reset = 1'b1;

        // Clean lock on channel 5, first pulse 10 cycles after reset release
        tick(10);
        pulse(5);
        check("cap_sel5", 32'(sel_channel), 32'd5);
        check("cap_state", 32'(state_dbg), 32'd1);
        for (int h = 1; h <= LOCK_COUNT; h++) begin
            tick(FRAME_LEN - 1);
            check("prelock_locked", 32'(locked), 32'd0);
            pulse(5);
        end
        check("lock_rise", 32'(locked), 32'd1);
        check("lock_valid", 32'(valid_o), 32'd1);
        check("lock_data", 32'(dataout), 32'hA5C3);
        for (int k = 0; k < 2; k++) begin
            tick(FRAME_LEN - 1);
            pulse(5);
            check("locked_valid", 32'(valid_o), 32'd1);
            check("locked_data", 32'(dataout), 32'hA5C3);
        end

        // Miss recovery: three missed frames then a hit, twice
        for (int k = 0; k < 2; k++) begin
            tick(4 * FRAME_LEN - 1);
            check("miss3_locked", 32'(locked), 32'd1);
            pulse(5);
            check("recover_valid", 32'(valid_o), 32'd1);
        end
        check("recover_relock", 32'(relock_count), 32'd0);

        // force_realign coincident with a hit while locked
        tick(FRAME_LEN - 1);
        valid_in      = 16'd1 << 5;
        force_realign = 1'b1;
        tick(1);
        valid_in      = 16'd0;
        force_realign = 1'b0;
        check("force_state", 32'(state_dbg), 32'd3);
        check("force_lost", 32'(lock_lost), 32'd1);
        check("force_relock", 32'(relock_count), 32'd1);
        check("force_valid", 32'(valid_o), 32'd0);
        check("force_data_hold", 32'(dataout), 32'hA5C3);
        tick(1);
        check("force_lost_pulse", 32'(lock_lost), 32'd0);
        tick(HOLDOFF_CYCLES);
        check("force_back_search", 32'(state_dbg), 32'd0);

        // Priority: channels 3 and 9 together, then off-phase pulse
        valid_in = (16'd1 << 3) | (16'd1 << 9);
        tick(1);
        valid_in = 16'd0;
        check("prio_sel", 32'(sel_channel), 32'd3);
        tick(6);
        pulse(3);
        check("wrongphase3_state", 32'(state_dbg), 32'd0);

        // Wrong phase in CONFIRM on channel 2
        pulse(2);
        check("cap_sel2", 32'(sel_channel), 32'd2);
        tick(6);
        pulse(2);
        check("wrongphase2_state", 32'(state_dbg), 32'd0);
        check("wrongphase2_locked", 32'(locked), 32'd0);
        check("wrongphase2_relock", 32'(relock_count), 32'd1);

        // force_realign in SEARCH has no effect
        force_realign = 1'b1;
        tick(1);
        force_realign = 1'b0;
        check("force_search_relock", 32'(relock_count), 32'd1);
        check("force_search_state", 32'(state_dbg), 32'd0);

        // Lock on channel 7, then drop valid entirely
        pulse(7);
        for (int h = 1; h <= LOCK_COUNT; h++) begin
            tick(FRAME_LEN - 1);
            pulse(7);
        end
        check("lock7", 32'(locked), 32'd1);
        check("lock7_data", 32'(dataout), 32'h7E57);
        tick(4 * FRAME_LEN - 1);
        check("loss_pre_locked", 32'(locked), 32'd1);
        check("loss_pre_lost", 32'(lock_lost), 32'd0);
        tick(1);
        check("loss_lost", 32'(lock_lost), 32'd1);
        check("loss_relock", 32'(relock_count), 32'd2);
        check("loss_locked", 32'(locked), 32'd0);
        valid_in = 16'd1 << 9;
        tick(1);
        check("loss_lost_pulse", 32'(lock_lost), 32'd0);
        tick(HOLDOFF_CYCLES - 2);
        check("holdoff_state", 32'(state_dbg), 32'd3);
        check("holdoff_sel", 32'(sel_channel), 32'd7);
        tick(1);
        check("holdoff_exit_state", 32'(state_dbg), 32'd0);
        check("holdoff_exit_sel", 32'(sel_channel), 32'd7);
        tick(1);
        check("recapture_sel", 32'(sel_channel), 32'd9);
        check("recapture_state", 32'(state_dbg), 32'd1);
        valid_in = 16'd0;

        // Asynchronous reset mid-CONFIRM
        tick(3);
        check("pre_reset_state", 32'(state_dbg), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick(2);
        reset = 1'b1;
        tick(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ttc_lock_ctrl.md
Name: ttc_lock_ctrl

Overview:
- Lock controller for the 16-channel TTC word aligner.
- Watches the 16 per-bit-offset shift-register valid flags and selects one channel as the word-alignment candidate.
- Confirms the candidate with a run of periodic hits, then declares lock and forwards that channel's 16-bit words.
- Monitors lock, declares loss after consecutive missed words and re-enters search after a holdoff. Sits between the SR16 channel bank and the command decoder.

Parameters:
FRAME_LEN, 16, clocks between successive valid pulses of an aligned channel (>=2)
LOCK_COUNT, 8, consecutive on-phase hits required to declare lock (1..255)
UNLOCK_COUNT, 4, consecutive on-phase misses that drop lock (1..255)
HOLDOFF_CYCLES, 32, idle clocks between lock loss and new search (>=1)

Ports:
clk  in  1  system clock (TTC bit clock domain)
reset  in  1  asynchronous active-low reset
valid_in  in  16  per-channel word-valid flags; bit i belongs to channel i
data_in  in  256  channel words concatenated; channel i = data_in[16*i+15:16*i]
force_realign  in  1  single-cycle request to abandon the current channel and search again
valid_o  out  1  registered word strobe, only while locked
dataout  out  16  registered word of the selected channel
locked  out  1  high in LOCKED state
sel_channel  out  4  current candidate/locked channel index
lock_lost  out  1  one-cycle pulse on LOCKED->HOLDOFF transition
relock_count  out  8  saturating count of lock losses and force_realign events

Behaviour:
- Reset (reset low, async): state=SEARCH; all outputs 0; phase_cnt, hit_cnt, miss_cnt, hold_cnt = 0. Deassertion takes effect on the next clk edge.
- phase_cnt counts 0..FRAME_LEN-1 and wraps. "On-phase" means phase_cnt==FRAME_LEN-1. "Hit" means on-phase with valid_in[sel_channel]=1.
- SEARCH:
  - If any valid_in bit is 1: sel_channel <= index of the lowest set bit, phase_cnt <= 0, hit_cnt <= 0, go to CONFIRM.
  - Otherwise stay in SEARCH.
- CONFIRM:
  - phase_cnt advances every clock.
  - Hit: hit_cnt+1. If that makes hit_cnt==LOCK_COUNT, go to LOCKED with miss_cnt <= 0.
  - On-phase without valid, or valid_in[sel_channel] high off-phase: go to SEARCH. No relock_count increment.
- LOCKED:
  - locked=1; phase_cnt continues to free-run.
  - Hit: miss_cnt <= 0.
  - On-phase miss: miss_cnt+1. Reaching UNLOCK_COUNT goes to HOLDOFF, pulses lock_lost for 1 cycle and increments relock_count.
  - Off-phase valid_in[sel_channel] is ignored.
- HOLDOFF:
  - hold_cnt counts to HOLDOFF_CYCLES-1, then go to SEARCH with hold_cnt cleared.
  - valid_in is ignored.
- force_realign:
  - In CONFIRM or LOCKED: go to HOLDOFF next cycle and increment relock_count.
  - lock_lost pulses only if leaving LOCKED.
  - In SEARCH or HOLDOFF: no effect.
  - Takes priority over a simultaneous hit or miss.
- Data path:
  - On a hit in LOCKED, the next cycle gives valid_o=1 and dataout=selected word. Latency is 1 clock.
  - The hit that completes LOCK_COUNT in CONFIRM also produces valid_o on the following cycle.
  - dataout holds its last value when valid_o=0.
  - valid_o is 0 in every other state.
- relock_count saturates at 255.
- sel_channel holds its value through HOLDOFF and SEARCH until a new capture.

Test Plan:
- Clean lock: after reset, drive valid_in[5] every 16 cycles starting at cycle 10 with word 16'hA5C3. Required: sel_channel=5 at capture; locked rises on the cycle after the 8th on-phase hit; valid_o pulses with dataout=A5C3 every 16 cycles.
- Priority: assert bits 3 and 9 together in SEARCH. Required: sel_channel=3.
- Wrong phase in CONFIRM: capture ch2, then pulse valid_in[2] 7 cycles later. Required: return to SEARCH; locked stays 0; relock_count stays 0.
- Loss of lock: after lock on ch7, drop valid_in entirely. Required: lock_lost pulses 1 cycle on the 4th missed on-phase (64 clocks); relock_count=1; no capture for 32 clocks even if valid_in is driven; SEARCH afterwards.
- Miss recovery: while locked, 3 misses then a hit, repeated. Required: locked never drops.
- force_realign coincident with a hit while locked: state goes to HOLDOFF; lock_lost=1; relock_count increments; valid_o for that hit is suppressed. Then assert reset mid-CONFIRM: all outputs go to 0 immediately.
